// File: rtl/keycode_queue_pio_pkg.sv
// keyq_pkg: register map and bit positions for the keycode queue PIO.
// Shared by the RTL and the testbench.
package keyq_pkg;

    typedef enum logic [1:0] {
        KEYQ_ADDR_DATA   = 2'd0,
        KEYQ_ADDR_STATUS = 2'd1,
        KEYQ_ADDR_CTRL   = 2'd2,
        KEYQ_ADDR_LAST   = 2'd3
    } keyq_addr_e;

    // Status word bit positions; the count field sits at the bottom.
    localparam int EMPTY_BIT = 16;
    localparam int FULL_BIT  = 17;
    localparam int OVF_BIT   = 18;

    // Control word bit positions; only IEN_BIT is held, the others self-clear.
    localparam int FLUSH_BIT  = 0;
    localparam int OVFCLR_BIT = 1;
    localparam int IEN_BIT    = 2;

endpackage

// File: rtl/keycode_queue_pio_if.sv
// Bus bundle for keycode_queue_pio: Avalon-MM slave signals plus the
// valid/ready keycode stream. slave = the queue, master = CPU + consumer.
interface keycode_queue_pio_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] key_data;
    logic              key_valid;
    logic              key_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, key_ready,
        output readdata, key_data, key_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, key_ready,
        input  readdata, key_data, key_valid
    );
endinterface

// File: rtl/keycode_queue_pio_fifo.sv
// keyq_sync_fifo: generic synchronous FIFO with flush. Storage resets to 0
// so dout is defined after reset. Flush beats push and pop; a push into a
// full FIFO is taken only if a pop happens in the same cycle.
module keyq_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; on full+pop the slot being vacated is the one written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/keycode_queue_pio.sv
// keycode_queue_pio: Avalon-MM keycode queue. CPU writes keycodes to
// address 0, downstream logic drains them over key_valid/key_ready.
// out_port keeps the last written keycode for legacy consumers.
// Build option: define KEYQ_IRQ_EN to add the irq output and irq_en bit.
module keycode_queue_pio
    import keyq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    keycode_queue_pio_if.slave bus,
    output logic [DATA_W-1:0] out_port
`ifdef KEYQ_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr, wr_data, wr_ctrl, pop;
    logic              flush, ovf_clr;
    logic              full, empty;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] key_data;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] out_port_q;
    logic [31:0]       status, ctrl_rd, rdata;
    logic              unused_wdata;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_data = wr & (bus.address == KEYQ_ADDR_DATA);
    assign wr_ctrl = wr & (bus.address == KEYQ_ADDR_CTRL);
    assign flush   = wr_ctrl & bus.writedata[FLUSH_BIT];
    assign ovf_clr = wr_ctrl & bus.writedata[OVFCLR_BIT];
    assign pop     = bus.key_valid & bus.key_ready;

    // Upper writedata bits are don't-care; folded here to keep them visibly sunk.
    assign unused_wdata = ^bus.writedata;

    keyq_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data),
        .pop     (pop),
        .flush   (flush),
        .din     (bus.writedata[DATA_W-1:0]),
        .dout    (key_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign bus.key_data  = key_data;
    assign bus.key_valid = ~empty;
    assign out_port      = out_port_q;

    // Sticky overflow: a dropped push sets it, a set beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (wr_data & full & ~pop) ovf_d = 1'b1;
    end

    // Overflow flag and legacy last-keycode register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q      <= 1'b0;
            out_port_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            if (wr_data) out_port_q <= bus.writedata[DATA_W-1:0];
        end
    end

`ifdef KEYQ_IRQ_EN
    logic irq_en_q, irq_q;

    // Interrupt enable and registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= bus.writedata[IEN_BIT];
            irq_q <= irq_en_q & (ovf_q | ~empty);
        end
    end

    assign irq = irq_q;
`endif

    // Status and control read words.
    always_comb begin
        status              = '0;
        status[CNT_W-1:0]   = count;
        status[EMPTY_BIT]   = empty;
        status[FULL_BIT]    = full;
        status[OVF_BIT]     = ovf_q;
        ctrl_rd             = '0;
`ifdef KEYQ_IRQ_EN
        ctrl_rd[IEN_BIT]    = irq_en_q;
`endif
    end

    // Combinational read mux; reading address 0 peeks without popping.
    always_comb begin
        rdata = '0;
        case (bus.address)
            KEYQ_ADDR_DATA:   rdata = 32'(key_data);
            KEYQ_ADDR_STATUS: rdata = status;
            KEYQ_ADDR_CTRL:   rdata = ctrl_rd;
            KEYQ_ADDR_LAST:   rdata = 32'(out_port_q);
            default:          rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
endmodule

// File: tb/tb_keycode_queue_pio.sv
// Self-checking bench for keycode_queue_pio: directed vector table, irq and
// async-reset sequences, then randomized traffic against a queue model.
module tb_keycode_queue_pio;
    import keyq_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] out_port;
`ifdef KEYQ_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    keycode_queue_pio_if #(.DATA_W(DW)) bus ();

    keycode_queue_pio #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
`ifdef KEYQ_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_ien;
    bit            m_irq;
    logic [DW-1:0] m_last;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        bit          ready;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_valid;
        logic [31:0] exp_kd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit wr, logic [1:0] addr, logic [31:0] wdata, bit ready,
                                bit chk_rd, logic [31:0] exp_rd, bit exp_valid,
                                logic [31:0] exp_kd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.ready = ready;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_kd = exp_kd;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_ovf  = 0;
        m_ien  = 0;
        m_irq  = 0;
        m_last = '0;
    endfunction

    function automatic logic [31:0] m_readdata(logic [1:0] addr);
        logic [31:0] r;
        r = '0;
        case (addr)
            KEYQ_ADDR_DATA:   r = (mq.size() != 0) ? 32'(mq[0]) : 32'h0;
            KEYQ_ADDR_STATUS: r = mq.size() | ((mq.size() == 0) ? (32'h1 << EMPTY_BIT) : 32'h0)
                                  | ((mq.size() == DEPTH) ? (32'h1 << FULL_BIT) : 32'h0)
                                  | (m_ovf ? (32'h1 << OVF_BIT) : 32'h0);
            KEYQ_ADDR_CTRL:   r = m_ien ? (32'h1 << IEN_BIT) : 32'h0;
            default:          r = 32'(m_last);
        endcase
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void step_model();
        int  sz;
        bit  pop, wr, nirq;
        sz   = mq.size();
        pop  = (sz != 0) && bus.key_ready;
        wr   = bus.chipselect && !bus.write_n;
        nirq = m_ien && (m_ovf || sz != 0);
        if (wr && bus.address == KEYQ_ADDR_DATA) begin
            m_last = bus.writedata[DW-1:0];
            if (sz < DEPTH || pop) begin
                if (pop) void'(mq.pop_front());
                pop = 0;
                mq.push_back(bus.writedata[DW-1:0]);
            end else begin
                m_ovf = 1;
            end
        end
        if (wr && bus.address == KEYQ_ADDR_CTRL) begin
            if (bus.writedata[FLUSH_BIT]) begin
                mq.delete();
                pop = 0;
            end
            if (bus.writedata[OVFCLR_BIT]) m_ovf = 0;
`ifdef KEYQ_IRQ_EN
            m_ien = bus.writedata[IEN_BIT];
`endif
        end
        if (pop) void'(mq.pop_front());
        m_irq = nirq;
    endfunction

    task automatic drive(bit wr, logic [1:0] addr, logic [31:0] wdata, bit ready);
        bus.chipselect = wr;
        bus.write_n    = ~wr;
        bus.address    = addr;
        bus.writedata  = wdata;
        bus.key_ready  = ready;
    endtask

    task automatic check_all(string tag);
        check({tag, "_valid"}, 32'(bus.key_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, "_kdata"}, 32'(bus.key_data), 32'(mq[0]));
        if (!(bus.address == KEYQ_ADDR_DATA && mq.size() == 0))
            check({tag, "_rdata"}, bus.readdata, m_readdata(bus.address));
        check({tag, "_out_port"}, 32'(out_port), 32'(m_last));
`ifdef KEYQ_IRQ_EN
        check({tag, "_irq"}, 32'(irq), 32'(m_irq));
`endif
    endtask

    // One cycle: drive at negedge, compare against model, step model, take edge.
    task automatic tick(string tag, bit wr, logic [1:0] addr, logic [31:0] wdata, bit ready);
        @(negedge clk);
        drive(wr, addr, wdata, ready);
        #1;
        check_all(tag);
        step_model();
        @(posedge clk);
    endtask

    initial begin
        drive(0, 2'd0, 32'h0, 0);
        m_reset();

        // Directed vectors, expectations written from the register map.
        add(0, 2'd1, 0, 0, 1, 32'h0001_0000, 0, 0);
        add(0, 2'd3, 0, 0, 1, 32'h0,         0, 0);
        add(0, 2'd2, 0, 0, 1, 32'h0,         0, 0);
        add(0, 2'd0, 0, 0, 1, 32'h0,         0, 0);
        add(1, 2'd0, 32'h1A, 0, 0, 0,        0, 0);
        add(1, 2'd0, 32'h04, 0, 1, 32'h1A,   1, 32'h1A);
        add(1, 2'd0, 32'h16, 0, 1, 32'h1A,   1, 32'h1A);
        add(0, 2'd1, 0, 0, 1, 32'h3,         1, 32'h1A);
        add(0, 2'd3, 0, 0, 1, 32'h16,        1, 32'h1A);
        add(0, 2'd0, 0, 1, 1, 32'h1A,        1, 32'h1A);
        add(0, 2'd0, 0, 1, 1, 32'h04,        1, 32'h04);
        add(0, 2'd0, 0, 1, 1, 32'h16,        1, 32'h16);
        add(0, 2'd1, 0, 0, 1, 32'h0001_0000, 0, 0);
        for (int k = 1; k <= 9; k++)
            add(1, 2'd0, 32'hFFFF_FF00 | k, 0, k > 1, 32'h01, k > 1, 32'h01);
        add(0, 2'd1, 0, 0, 1, 32'h0006_0008, 1, 32'h01);
        add(1, 2'd2, 32'h2, 0, 1, 32'h0,     1, 32'h01);
        add(0, 2'd1, 0, 0, 1, 32'h0002_0008, 1, 32'h01);
        add(1, 2'd0, 32'h2C, 1, 1, 32'h01,   1, 32'h01);
        add(0, 2'd1, 0, 0, 1, 32'h0002_0008, 1, 32'h02);
        for (int k = 2; k <= 8; k++)
            add(0, 2'd0, 0, 1, 1, k, 1, k);
        add(0, 2'd0, 0, 1, 1, 32'h2C,        1, 32'h2C);
        add(0, 2'd1, 0, 0, 1, 32'h0001_0000, 0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 2'd0, 32'h31 + k, 0, k > 0, 32'h31, k > 0, 32'h31);
        add(1, 2'd2, 32'h1, 1, 1, 32'h0,     1, 32'h31);
        add(0, 2'd1, 0, 0, 1, 32'h0001_0000, 0, 0);
        add(0, 2'd3, 0, 0, 1, 32'h35,        0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("reset_out_port", 32'(out_port), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
            #1;
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), bus.readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_valid", i), 32'(bus.key_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_kdata", i), 32'(bus.key_data), vecs[i].exp_kd);
            step_model();
            @(posedge clk);
        end

`ifdef KEYQ_IRQ_EN
        // Interrupt follows non-empty while enabled and drops after a flush.
        tick("irq_en", 1, 2'd2, 32'h4, 0);
        tick("irq_push", 1, 2'd0, 32'h41, 0);
        tick("irq_wait", 0, 2'd2, 32'h0, 0);
        #1 check("irq_high", 32'(irq), 32'h1);
        tick("irq_flush", 1, 2'd2, 32'h5, 0);
        tick("irq_wait2", 0, 2'd1, 32'h0, 0);
        #1 check("irq_low", 32'(irq), 32'h0);
        tick("irq_dis", 1, 2'd2, 32'h0, 0);
`endif

        // Asynchronous reset in mid-cycle discards queued entries at once.
        tick("pre_rst0", 1, 2'd0, 32'h51, 0);
        tick("pre_rst1", 1, 2'd0, 32'h52, 0);
        tick("pre_rst2", 1, 2'd0, 32'h53, 0);
        #2;
        drive(0, 2'd1, 32'h0, 0);
        reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.key_valid), 32'h0);
        check("rst_status", bus.readdata, 32'h0001_0000);
        check("rst_out_port", 32'(out_port), 32'h0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            int          r;
            bit          wr;
            logic [1:0]  addr;
            logic [31:0] wd;
            r    = $urandom_range(0, 99);
            wd   = $urandom();
            wr   = 0;
            addr = 2'($urandom_range(0, 3));
            if (r < 40) begin
                wr = 1; addr = KEYQ_ADDR_DATA;
            end else if (r < 46) begin
                wr = 1; addr = KEYQ_ADDR_CTRL;
                wd[FLUSH_BIT] = ($urandom_range(0, 3) == 0);
            end else if (r < 50) begin
                wr = 1; addr = ($urandom_range(0, 1) != 0) ? KEYQ_ADDR_STATUS : KEYQ_ADDR_LAST;
            end
            tick("rnd", wr, addr, wd, $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keycode_queue_pio.md
Name: keycode_queue_pio

Overview:
- Parametrised successor to the single-register keycode output port: Avalon-MM slave, 4-word address space, zero wait states, combinational readdata.
- Software (NIOS) writes keycodes into a DEPTH-entry FIFO instead of a single register.
- Downstream game/video logic drains the FIFO over a valid/ready stream, so no keypress is lost between frames.
- A legacy level output holding the last written keycode is retained for existing consumers.

Parameters:
- DATA_W, 8, keycode width in bits. Legal range 1..32.
- DEPTH, 8, FIFO entries. Power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), count field width. Derived; not overridable.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational from address.
- out_port  out  DATA_W  last keycode written to address 0, held.
- key_data  out  DATA_W  FIFO head keycode.
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts head this cycle.
- irq  out  1  interrupt (present only with KEYQ_IRQ_EN).

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk; all state rising-edge.
  - Reset clears rd_ptr, wr_ptr, count, overflow, irq_en and out_port to 0.
  - Outputs after reset: key_valid=0, key_data=0 (storage reset to 0), irq=0.
  - Reset mid-operation discards all queued entries immediately.
- Write strobe: wr = chipselect & ~write_n. pop = key_valid & key_ready.
- Address 0 write (push):
  - out_port <= writedata[DATA_W-1:0] unconditionally.
  - Push accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle (count unchanged).
  - Push rejected (data dropped, overflow<=1 sticky) if count==DEPTH and no pop.
  - Bits above DATA_W are ignored.
- Address 0 read: {zero-extend, key_data} (peek only; does not pop).
- Address 1 read (status):
  - [CW-1:0] count.
  - [16] empty.
  - [17] full.
  - [18] overflow.
  - Other bits 0. Writes ignored.
- Address 2 write (control):
  - bit0 flush: rd_ptr, wr_ptr, count <= 0; a same-cycle pop is discarded; overflow unaffected.
  - bit1 clear overflow. If the same cycle also has a rejected push, the set wins (no push is possible on the same cycle, since only one address is written per cycle).
  - bit2 irq_en.
  - Bits self-clear except irq_en. Address 2 read: {29'b0, irq_en, 2'b0}.
- Address 3 read: zero-extended out_port. Writes ignored.
- Latency:
  - Accepted push visible on key_valid/key_data the next cycle.
  - pop advances the head the next cycle.
  - Status reflects registered state, i.e. one cycle after the event.
- Count update: count + push_acc - pop_acc, never outside 0..DEPTH.
- Pointers: log2(DEPTH) bits; natural wrap-around; full/empty derived from count.
- key_data: combinational read of storage at rd_ptr. Value is undefined-but-stable when key_valid=0; the bench must not check it then.
- Simultaneous push+pop when empty: pop impossible (key_valid=0); push accepted; count becomes 1.

Optional Feature:
- Macro KEYQ_IRQ_EN defined:
  - irq port exists; irq = irq_en & (overflow | ~empty), registered, level-sensitive.
  - Cleared by draining the FIFO and clearing overflow, or by clearing irq_en.
- Undefined:
  - No irq port; irq_en flop removed; control bit2 ignored; address 2 reads all-zero.

Decomposition:
- Shared package keyq_pkg:
  - Address constants KEYQ_ADDR_DATA=0, KEYQ_ADDR_STATUS=1, KEYQ_ADDR_CTRL=2, KEYQ_ADDR_LAST=3.
  - Status bit positions (EMPTY_BIT=16, FULL_BIT=17, OVF_BIT=18).
  - Control bit positions (FLUSH_BIT=0, OVFCLR_BIT=1, IEN_BIT=2).
- One sub-module: keyq_sync_fifo, a generic synchronous FIFO.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Parameters: DATA_W, DEPTH.
  - The top holds the Avalon decode, overflow/irq logic and out_port.

Test Plan:
- Reset, then read all addresses:
  - status reads 0x0001_0000 (empty); out_port=0; key_valid=0.
- Write 0x1A, 0x04, 0x16 to addr0 with key_ready=0:
  - status count=3; out_port=0x16; key_valid=1; key_data=0x1A.
- Then key_ready=1 for 3 cycles:
  - key_data sequence 0x1A, 0x04, 0x16; key_valid=0 afterwards; status empty.
- DEPTH=8, 9 writes 0x01..0x09 with no pop:
  - count=8, full=1, overflow=1; drain yields 0x01..0x08.
  - Write ctrl=0x2: overflow=0.
- Full FIFO, addr0 write 0x2C in the same cycle as a pop:
  - push accepted; count stays 8; overflow stays 0; 0x2C is the last entry out.
- Queue 5 entries, write ctrl=0x1 while key_ready=1:
  - next cycle count=0, key_valid=0; out_port unchanged.
  - With KEYQ_IRQ_EN and irq_en=1: irq=1 while non-empty, 0 after flush.
